// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, PC step,
// default reset address and the fetch-buffer entry layout.
package instruction_fetch_unit_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Small circular FIFO of {PC, instruction} entries with push/pop/flush.
// DEPTH is expected to be 2 or 4, so pointers wrap naturally at DEPTH.
module fetch_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic                                i_push,
  input  logic                                i_pop,
  input  logic                                i_flush,
  input  logic [63:0]                         i_data,
  output logic [63:0]                         o_head,
  output logic [((DEPTH > 2) ? 3 : 2)-1:0]    o_count,
  output logic                                o_valid
);

  localparam int unsigned PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_pop;
  logic w_push;

  // Guards keep count inside [0, DEPTH] even if a caller misbehaves.
  assign w_pop  = i_pop & (r_count != '0);
  assign w_push = i_push & ((r_count < FULL) | w_pop);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_valid = (r_count != '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register and IDLE/RUN control feeding a small
// fetch buffer; consumer outputs come only from buffered head registers.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Enable,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        FetchValid,
  input  logic        FetchReady,
  output logic [31:0] FetchInstruction,
  output logic [31:0] FetchPC
);

  localparam int unsigned CNT_W = (DEPTH > 2) ? 3 : 2;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;

  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
      r_pc    <= word_align(RESET_PC);
    end else begin
      r_state <= w_state_next;
      if (BranchTaken) begin
        r_pc <= word_align(BranchTarget);
      end else if (w_push) begin
        r_pc <= r_pc + PC_INCR;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    case (r_state)
      IDLE: begin
        if (Enable) w_state_next = RUN;
      end
      RUN: begin
        if (!Enable) w_state_next = IDLE;
        w_push = !BranchTaken && ((w_count < FULL) || w_pop);
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_pop        = w_valid & FetchReady;
  assign w_push_entry = '{pc: r_pc, instr: IMemInstruction};
  assign IMemAddress  = {r_pc[31:2], 2'b00};

  fetch_buffer #(
    .DEPTH(DEPTH)
  ) u_fetch_buffer (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (BranchTaken),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_valid (w_valid)
  );

  assign FetchValid       = w_valid;
  assign FetchPC          = w_head.pc;
  assign FetchInstruction = w_head.instr;

endmodule
